fifo_write_arbiter: RTL

- Shares a single FIFO write port (din/write/full, DATA_WIDTH-wide) between N_REQ producer actors in the multi-dataflow fabric.
- Each producer uses a valid/ready handshake toward the arbiter.
- Grants are round-robin and burst-locked: a winner holds the port for up to MAX_BURST tokens before fairness rotation.
- Sits directly in front of the FIFO write interface; read side untouched.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_priority_picker.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
//   arb_state_t  : arbiter FSM states
//   DEF_*        : default DATA_WIDTH / N_REQ / MAX_BURST
//   onehot2idx   : index of the set bit of a one-hot vector (0 if none)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_BURST  = 4;

  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker (combinational).
//   req         : request vector
//   last_winner : index of the previous winner; scanning starts one above it
//   pick        : first requester found scanning last_winner+1 .. last_winner+N_REQ (mod N_REQ)
//   any_req     : at least one request is set
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  logic found;

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    any_req = |req;
    // Offset k = N_REQ wraps back onto last_winner itself, so a lone
    // repeat requester is still picked.
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last_winner) + k) % N_REQ]) begin
        pick  = IDX_W'((int'(last_winner) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among N_REQ
// valid/ready producers. A winner keeps the port until it has written
// MAX_BURST tokens or drops valid; each release costs one IDLE cycle.
//   clk, rst    : clock, synchronous active-high reset
//   req_data    : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid   : requester i has a token
//   req_ready   : requester i token accepted when valid&ready
//   grant       : registered one-hot owner, zero when idle
//   fifo_din    : data to FIFO
//   fifo_write  : FIFO write strobe
//   fifo_full   : FIFO full flag
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic                        fifo_write,
  input  logic                        fifo_full
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0] last_winner_q, last_winner_d;

  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [IDX_W-1:0] owner;
  logic             owner_vld;
  logic             last_beat;

  rr_priority_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req         (req_valid),
    .last_winner (last_winner_q),
    .pick        (pick),
    .any_req     (any_req)
  );

  assign owner     = IDX_W'(onehot2idx(32'(grant_q)));
  assign owner_vld = req_valid[owner];
  assign grant     = grant_q;

  // Datapath / handshake. Gated by rst so nothing is accepted or written in
  // a reset cycle even if a burst was in flight.
  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_din   = '0;
    if (state_q == GRANT && !rst) begin
      fifo_din         = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      req_ready[owner] = !fifo_full;
      fifo_write       = owner_vld && !fifo_full;
    end
  end

  assign last_beat = fifo_write && (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    burst_cnt_d   = burst_cnt_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = GRANT;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          burst_cnt_d   = '0;
        end
      end
      GRANT: begin
        // Full stalls the burst but never releases it.
        if (!owner_vld || last_beat) begin
          state_d       = IDLE;
          grant_d       = '0;
          burst_cnt_d   = '0;
          last_winner_d = owner;
        end else if (fifo_write) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      burst_cnt_q   <= '0;
      last_winner_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      burst_cnt_q   <= burst_cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

endmodule
